// File: rtl/t05_mem_arbiter.sv
// ---------------------------------------------------------------------------
// t05_mem_arbiter
// Shares one Wishbone-style SRAM master port between the Huffman pipeline
// requesters (0=HISTO, 1=FLV/HTREE, 2=CBS, 3=TRN). The pipeline state picks
// which requesters may use the bus. Eligible requesters are served
// round-robin, one transaction at a time. Each transaction ends with a
// one-cycle done pulse to its requester. A bus timeout also raises a
// one-cycle err pulse, together with that done pulse.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   state_reg[3:0]         pipeline state, selects the eligibility mask
//   req/req_we[NREQ]       per-requester request level and write flag
//   req_addr/req_wdata     flattened per-requester address / write data
//   done[NREQ], rdata      one-hot completion pulse and read data
//   mem_cyc/we/adr/dat_o   bus master outputs
//   mem_dat_i, mem_ack     bus read data and acknowledge
//   err                    timeout abort pulse
//   busy                   high while a transaction is in flight (BUS/RESP)
// ---------------------------------------------------------------------------
module t05_mem_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        state_reg,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              mem_cyc,
  output logic              mem_we,
  output logic [AW-1:0]     mem_adr,
  output logic [DW-1:0]     mem_dat_o,
  input  logic [DW-1:0]     mem_dat_i,
  input  logic              mem_ack,
  output logic              err,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} fsm_t;

  fsm_t          fsm_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] win_reg;
  logic [CW-1:0] cnt_reg;

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   rr_next;

  // Unpack the flattened request buses so the grant can index them directly.
  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  // Pipeline state -> requesters allowed on the bus.
  always_comb begin
    mask = '0;
    case (state_reg)
      4'd1: mask[0] = 1'b1;                      // HISTO
      4'd2: mask[1] = 1'b1;                      // FLV
      4'd3: begin mask[1] = 1'b1; mask[2] = 1'b1; end  // HTREE
      4'd4: begin mask[2] = 1'b1; mask[3] = 1'b1; end  // CBS
      4'd5: begin mask[2] = 1'b1; mask[3] = 1'b1; end  // TRN
      default: mask = '0;
    endcase
  end

  assign eligible = req & mask;

  // Round-robin search: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  assign rr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg    <= S_IDLE;
      rr_ptr_reg <= '0;
      win_reg    <= '0;
      cnt_reg    <= '0;
      done       <= '0;
      rdata      <= '0;
      mem_cyc    <= 1'b0;
      mem_we     <= 1'b0;
      mem_adr    <= '0;
      mem_dat_o  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (fsm_reg)
        S_IDLE: begin
          if (found) begin
            // Request is latched here; later changes on req_* are ignored.
            win_reg    <= win_idx;
            rr_ptr_reg <= rr_next;
            mem_cyc    <= 1'b1;
            mem_we     <= req_we[win_idx];
            mem_adr    <= addr_arr[win_idx];
            mem_dat_o  <= wdata_arr[win_idx];
            cnt_reg    <= '0;
            busy       <= 1'b1;
            fsm_reg    <= S_BUS;
          end
        end
        S_BUS: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (mem_ack) begin
            mem_cyc       <= 1'b0;
            done[win_reg] <= 1'b1;
            rdata         <= mem_we ? '0 : mem_dat_i;
            fsm_reg       <= S_RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            mem_cyc       <= 1'b0;
            err           <= 1'b1;
            done[win_reg] <= 1'b1;
            rdata         <= '0;
            fsm_reg       <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_RESP: begin
          done    <= '0;
          err     <= 1'b0;
          rdata   <= '0;
          busy    <= 1'b0;
          fsm_reg <= S_IDLE;
        end
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_mem_arbiter.sv
module tb_t05_mem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        state_reg;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   done;
  logic [DW-1:0]     rdata;
  logic              mem_cyc;
  logic              mem_we;
  logic [AW-1:0]     mem_adr;
  logic [DW-1:0]     mem_dat_o;
  logic [DW-1:0]     mem_dat_i;
  logic              mem_ack;
  logic              err;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  t05_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .state_reg(state_reg),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rdata(rdata),
    .mem_cyc(mem_cyc), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack(mem_ack), .err(err), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a grant, checks the bus, acks after ack_dly more cycles and
  // checks the completion pulse.
  task automatic run_txn(input string tag, input int exp_win, input logic [31:0] exp_adr,
                         input logic exp_we, input logic [31:0] exp_wd,
                         input logic [31:0] ack_dat, input int ack_dly);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_cyc && lat < 20);
    check_val({tag, "_lat"}, 64'(lat), 64'd1);
    check_val({tag, "_adr"}, 64'(mem_adr), 64'(exp_adr));
    check_val({tag, "_we"},  64'(mem_we), 64'(exp_we));
    if (exp_we) check_val({tag, "_dat_o"}, 64'(mem_dat_o), 64'(exp_wd));
    repeat (ack_dly) @(negedge clk);
    mem_ack   = 1'b1;
    mem_dat_i = ack_dat;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_dat_i = '0;
    check_val({tag, "_done"},  64'(done), 64'(4'b0001 << exp_win));
    check_val({tag, "_rdata"}, 64'(rdata), exp_we ? 64'd0 : 64'(ack_dat));
    check_val({tag, "_err"},   64'(err), 64'd0);
    $display("txn %s win=%0d adr=%0h we=%0d done=%b rdata=%0h", tag, exp_win, mem_adr, mem_we, done, rdata);
    @(negedge clk);
    check_val({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n     = 1'b0;
    state_reg = 4'd0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_dat_i = '0;
    mem_ack   = 1'b0;
    req_addr[0*AW +: AW] = 32'h40;
    req_addr[1*AW +: AW] = 32'h1010;
    req_addr[2*AW +: AW] = 32'h1020;
    req_addr[3*AW +: AW] = 32'h1030;
    req_wdata[3*DW +: DW] = 32'hCAFE0003;
    req_we[3] = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_cyc",  64'(mem_cyc), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_err",  64'(err), 64'd0);
    check_val("rst_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // HISTO read, ack two cycles after mem_cyc rises
    state_reg = 4'd1;
    req       = 4'b0001;
    run_txn("histo", 0, 32'h40, 1'b0, 32'h0, 32'hDEADBEEF, 1);
    req = '0;

    // Stray ack in IDLE must not produce done
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("stray_ack_done", 64'(done), 64'd0);
    $display("txn stray_ack done=%b", done);

    // TRN: requesters 2 (read) and 3 (write) alternate
    state_reg = 4'd5;
    req       = 4'b1100;
    run_txn("rr_a", 2, 32'h1020, 1'b0, 32'h0, 32'h22220001, 0);
    run_txn("rr_b", 3, 32'h1030, 1'b1, 32'hCAFE0003, 32'h11111111, 0);
    run_txn("rr_c", 2, 32'h1020, 1'b0, 32'h0, 32'h22220002, 2);
    run_txn("rr_d", 3, 32'h1030, 1'b1, 32'hCAFE0003, 32'h11111111, 0);
    req = '0;

    // HISTO state with only non-HISTO requesters: no grant
    state_reg = 4'd1;
    req       = 4'b1110;
    seen      = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_cyc || busy) seen = 1'b1;
    end
    check_val("nogrant", 64'(seen), 64'd0);
    $display("txn nogrant seen=%0d", seen);
    req = '0;

    // Timeout: requester 2 alone, never acked
    req_we[2] = 1'b0;
    state_reg = 4'd4;
    req       = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_cyc && n < 20);
    check_val("to_lat", 64'(n), 64'd1);
    n = 0;
    while (mem_cyc && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_val("to_cyc_len", 64'(n), 64'(TO));
    check_val("to_err",  64'(err), 64'd1);
    check_val("to_done", 64'(done), 64'b0100);
    check_val("to_rdata", 64'(rdata), 64'd0);
    $display("txn timeout win=2 cycles=%0d err=%0d done=%b", n, err, done);
    req = '0;
    @(negedge clk);
    check_val("to_err_clr", 64'(err), 64'd0);
    check_val("to_done_clr", 64'(done), 64'd0);

    // Ack exactly on the expiry edge: ack wins
    req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_cyc && n < 20);
    check_val("exp_lat", 64'(n), 64'd1);
    repeat (TO - 1) @(negedge clk);
    check_val("exp_cyc_hi", 64'(mem_cyc), 64'd1);
    mem_ack   = 1'b1;
    mem_dat_i = 32'h5A5A0008;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_dat_i = '0;
    check_val("exp_err",  64'(err), 64'd0);
    check_val("exp_done", 64'(done), 64'b0100);
    check_val("exp_rdata", 64'(rdata), 64'h5A5A0008);
    $display("txn ack_on_expiry win=2 err=%0d done=%b rdata=%0h", err, done, rdata);
    req = '0;
    @(negedge clk);

    // State and req change while in BUS; transaction still completes
    state_reg = 4'd4;
    req       = 4'b1000;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_cyc && n < 20);
    check_val("chg_lat", 64'(n), 64'd1);
    state_reg = 4'd5;
    req       = '0;
    @(negedge clk);
    check_val("chg_cyc", 64'(mem_cyc), 64'd1);
    check_val("chg_adr", 64'(mem_adr), 64'h1030);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("chg_done", 64'(done), 64'b1000);
    check_val("chg_rdata", 64'(rdata), 64'd0);
    $display("txn state_change win=3 done=%b", done);
    @(negedge clk);

    // Asynchronous reset in BUS, then grant restarts from rr_ptr=0
    state_reg = 4'd4;
    req       = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_cyc && n < 20);
    check_val("ar_lat", 64'(n), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar_cyc",  64'(mem_cyc), 64'd0);
    check_val("ar_busy", 64'(busy), 64'd0);
    check_val("ar_done", 64'(done), 64'd0);
    $display("txn async_reset cyc=%0d busy=%0d", mem_cyc, busy);
    state_reg = 4'd5;
    req       = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    check_val("ar_hold_err",  64'(err), 64'd0);
    check_val("ar_hold_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_txn("post_rst", 2, 32'h1020, 1'b0, 32'h0, 32'h77770002, 0);
    req = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
